// File: rtl/soc_wb_split.sv
`default_nettype none
// ============================================================================
// Module   : soc_wb_split
// Purpose  : Registered Wishbone fan-out from the CPU bridge to N slaves, with
//            an access watchdog and sticky error-address capture.
// Revision : 1.0 - initial release
// ============================================================================
module soc_wb_split #(
    parameter int              N         = 8,
    parameter int              AW        = 16,
    parameter int              DW        = 32,
    parameter int              SW        = 4,
    parameter int              TO_CYCLES = 256,
    parameter logic [DW-1:0]   ERR_DATA  = 32'hDEADBEEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [AW-1:0]        s_addr,
    output logic [DW-1:0]        s_rdata,
    input  logic [DW-1:0]        s_wdata,
    input  logic [DW/8-1:0]      s_wmsk,
    input  logic                 s_we,
    input  logic                 s_cyc,
    output logic                 s_ack,
    output logic [AW-SW-1:0]     m_addr,
    input  logic [N*DW-1:0]      m_rdata,
    output logic [DW-1:0]        m_wdata,
    output logic [DW/8-1:0]      m_wmsk,
    output logic                 m_we,
    output logic [N-1:0]         m_cyc,
    input  logic [N-1:0]         m_ack,
    output logic                 err_flag,
    output logic [AW-1:0]        err_addr,
    output logic                 err_stb,
    input  logic                 err_clr
);

    localparam int              c_cw   = (TO_CYCLES > 0) ? $clog2(TO_CYCLES) + 1 : 1;
    localparam logic [c_cw-1:0] c_term = (TO_CYCLES > 0) ? c_cw'(TO_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_GAP  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [SW-1:0]     sel_q, sel_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic [DW/8-1:0]   wmsk_q, wmsk_d;
    logic              we_q, we_d;
    logic [N-1:0]      m_cyc_q, m_cyc_d;
    logic              s_ack_q, s_ack_d;
    logic [DW-1:0]     s_rdata_q, s_rdata_d;
    logic              err_flag_q, err_flag_d;
    logic [AW-1:0]     err_addr_q, err_addr_d;
    logic              err_stb_q, err_stb_d;
    logic [c_cw-1:0]   cnt_q, cnt_d;

    logic [SW-1:0]     w_sel;
    logic              w_sel_ok;
    logic              w_ack_hit;
    logic [DW-1:0]     w_rdata_hit;
    logic              w_err_set;

    assign w_sel    = s_addr[AW-1:AW-SW];
    assign w_sel_ok = ({1'b0, w_sel} < (SW+1)'(N));

    // Only the latched slave's ack and read data are ever looked at.
    always_comb begin
        w_ack_hit   = 1'b0;
        w_rdata_hit = '0;
        for (int i = 0; i < N; i++) begin
            if (sel_q == SW'(i)) begin
                w_ack_hit   = m_ack[i];
                w_rdata_hit = m_rdata[i*DW +: DW];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wmsk_d     = wmsk_q;
        we_d       = we_q;
        m_cyc_d    = m_cyc_q;
        s_ack_d    = s_ack_q;
        s_rdata_d  = s_rdata_q;
        err_flag_d = err_flag_q;
        err_addr_d = err_addr_q;
        err_stb_d  = 1'b0;
        cnt_d      = cnt_q;
        w_err_set  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (s_cyc) begin
                    sel_d   = w_sel;
                    addr_d  = s_addr;
                    wdata_d = s_wdata;
                    wmsk_d  = s_wmsk;
                    we_d    = s_we;
                    cnt_d   = '0;
                    for (int i = 0; i < N; i++) begin
                        m_cyc_d[i] = w_sel_ok && (w_sel == SW'(i));
                    end
                    state_d = w_sel_ok ? ST_REQ : ST_RESP;
                end
            end
            ST_REQ: begin
                // A slave ack on the terminal count takes priority over the timeout.
                if (w_ack_hit) begin
                    m_cyc_d   = '0;
                    s_ack_d   = 1'b1;
                    s_rdata_d = we_q ? '0 : w_rdata_hit;
                    state_d   = ST_RESP;
                end else if ((TO_CYCLES != 0) && (cnt_q == c_term)) begin
                    m_cyc_d   = '0;
                    s_ack_d   = 1'b1;
                    w_err_set = 1'b1;
                    state_d   = ST_RESP;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                // Arriving here without an ack means a decode error is still owed.
                if (s_ack_q) begin
                    s_ack_d = 1'b0;
                    state_d = ST_GAP;
                end else begin
                    s_ack_d   = 1'b1;
                    w_err_set = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (w_err_set) begin
            s_rdata_d  = ERR_DATA;
            err_stb_d  = 1'b1;
            err_addr_d = addr_q;
            err_flag_d = 1'b1;
        end else if (err_clr) begin
            err_flag_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            sel_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wmsk_q     <= '0;
            we_q       <= 1'b0;
            m_cyc_q    <= '0;
            s_ack_q    <= 1'b0;
            s_rdata_q  <= '0;
            err_flag_q <= 1'b0;
            err_addr_q <= '0;
            err_stb_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wmsk_q     <= wmsk_d;
            we_q       <= we_d;
            m_cyc_q    <= m_cyc_d;
            s_ack_q    <= s_ack_d;
            s_rdata_q  <= s_rdata_d;
            err_flag_q <= err_flag_d;
            err_addr_q <= err_addr_d;
            err_stb_q  <= err_stb_d;
            cnt_q      <= cnt_d;
        end
    end

    assign s_rdata  = s_rdata_q;
    assign s_ack    = s_ack_q;
    assign m_addr   = addr_q[AW-SW-1:0];
    assign m_wdata  = wdata_q;
    assign m_wmsk   = wmsk_q;
    assign m_we     = we_q;
    assign m_cyc    = m_cyc_q;
    assign err_flag = err_flag_q;
    assign err_addr = err_addr_q;
    assign err_stb  = err_stb_q;

endmodule
`default_nettype wire

// File: tb/tb_soc_wb_split.sv
`default_nettype none
// ============================================================================
// Module   : tb_soc_wb_split
// Purpose  : Scoreboard bench for soc_wb_split (watchdog on and off instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_soc_wb_split;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [15:0] addr;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [15:0]  s_addr = '0;
    logic [31:0]  s_wdata = '0;
    logic [3:0]   s_wmsk = '0;
    logic         s_we = 1'b0;
    logic         s_cyc = 1'b0;
    logic         s_cyc_b = 1'b0;
    logic         err_clr = 1'b0;
    logic         err_clr_b = 1'b0;
    logic [255:0] m_rdata;
    logic [7:0]   m_ack = '0;
    logic [7:0]   m_ack_b = '0;

    logic [31:0]  s_rdata, s_rdata_b, m_wdata, m_wdata_b;
    logic         s_ack, s_ack_b, m_we, m_we_b;
    logic [11:0]  m_addr, m_addr_b;
    logic [3:0]   m_wmsk, m_wmsk_b;
    logic [7:0]   m_cyc, m_cyc_b;
    logic         err_flag, err_flag_b, err_stb, err_stb_b;
    logic [15:0]  err_addr, err_addr_b;

    int checks = 0;
    int errors = 0;
    int dly_a = 0;
    logic [7:0] noise_a = '0;
    int cnt_a = 0;
    int cnt_b = 0;
    logic ack_prev = 1'b0;
    exp_t q_a[$];
    exp_t q_b[$];

    always #5 clk = ~clk;

    soc_wb_split #(.N(8), .AW(16), .DW(32), .SW(4), .TO_CYCLES(16), .ERR_DATA(32'hDEADBEEF)) u_dut_a (
        .clk(clk), .rst(rst), .s_addr(s_addr), .s_rdata(s_rdata), .s_wdata(s_wdata),
        .s_wmsk(s_wmsk), .s_we(s_we), .s_cyc(s_cyc), .s_ack(s_ack), .m_addr(m_addr),
        .m_rdata(m_rdata), .m_wdata(m_wdata), .m_wmsk(m_wmsk), .m_we(m_we), .m_cyc(m_cyc),
        .m_ack(m_ack), .err_flag(err_flag), .err_addr(err_addr), .err_stb(err_stb), .err_clr(err_clr)
    );

    soc_wb_split #(.N(8), .AW(16), .DW(32), .SW(4), .TO_CYCLES(0), .ERR_DATA(32'hDEADBEEF)) u_dut_b (
        .clk(clk), .rst(rst), .s_addr(s_addr), .s_rdata(s_rdata_b), .s_wdata(s_wdata),
        .s_wmsk(s_wmsk), .s_we(s_we), .s_cyc(s_cyc_b), .s_ack(s_ack_b), .m_addr(m_addr_b),
        .m_rdata(m_rdata), .m_wdata(m_wdata_b), .m_wmsk(m_wmsk_b), .m_we(m_we_b), .m_cyc(m_cyc_b),
        .m_ack(m_ack_b), .err_flag(err_flag_b), .err_addr(err_addr_b), .err_stb(err_stb_b), .err_clr(err_clr_b)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Slave model: the selected slave acks on the dly_a-th cycle of m_cyc (0 = never).
    always @(negedge clk) begin
        if (m_cyc != 8'h00) begin
            cnt_a++;
            m_ack = ((dly_a != 0 && cnt_a == dly_a) ? m_cyc : 8'h00) | noise_a;
        end else begin
            cnt_a = 0;
            m_ack = noise_a;
        end
    end

    always @(negedge clk) begin
        if (m_cyc_b != 8'h00) begin
            cnt_b++;
            m_ack_b = (cnt_b == 1000) ? m_cyc_b : 8'h00;
        end else begin
            cnt_b = 0;
            m_ack_b = 8'h00;
        end
    end

    // Monitors: pop the scoreboard whenever an upstream ack is presented.
    always @(negedge clk) begin
        exp_t e;
        if (s_ack) begin
            chk("ack_pulse_width", ack_prev, 1'b0);
            chk("ack_expected", q_a.size() != 0, 1'b1);
            if (q_a.size() != 0) begin
                e = q_a.pop_front();
                chk("s_rdata", s_rdata, e.rdata);
                chk("err_stb", err_stb, e.err);
                if (e.err) begin
                    chk("err_addr", err_addr, e.addr);
                    chk("err_flag_set", err_flag, 1'b1);
                end
            end
        end else if (err_stb) begin
            chk("err_stb_without_ack", err_stb, 1'b0);
        end
        ack_prev = s_ack;
    end

    always @(negedge clk) begin
        exp_t e;
        if (s_ack_b) begin
            chk("b_ack_expected", q_b.size() != 0, 1'b1);
            if (q_b.size() != 0) begin
                e = q_b.pop_front();
                chk("b_s_rdata", s_rdata_b, e.rdata);
                chk("b_err_stb", err_stb_b, e.err);
            end
        end
    end

    task automatic txn(input logic [15:0] addr, input logic we, input logic [31:0] wd,
                       input logic [3:0] wm, input int dly, input logic [31:0] srd,
                       input logic [31:0] exp_rd, input logic exp_err, input logic [7:0] exp_cyc,
                       input int exp_lat, input int exp_cn);
        int lat = 0;
        int cn = 0;
        logic stable_ok = 1'b1;
        logic got = 1'b0;
        logic [3:0] sel = addr[15:12];
        repeat (3) @(negedge clk);
        if (sel < 4'd8) m_rdata[sel*32 +: 32] = srd;
        dly_a = dly;
        q_a.push_back('{rdata: exp_rd, err: exp_err, addr: addr});
        s_addr = addr; s_we = we; s_wdata = wd; s_wmsk = wm; s_cyc = 1'b1;
        while (!got && lat < 2000) begin
            @(negedge clk);
            lat++;
            if (m_cyc != 8'h00) begin
                cn++;
                if (m_cyc != exp_cyc || m_addr != addr[11:0] || m_we != we ||
                    m_wmsk != wm || m_wdata != wd) stable_ok = 1'b0;
            end
            if (s_ack) got = 1'b1;
        end
        s_cyc = 1'b0;
        chk("ack_latency", lat, exp_lat);
        chk("m_cyc_cycles", cn, exp_cn);
        chk("req_outputs_stable", stable_ok, 1'b1);
    endtask

    initial begin
        int lat;
        for (int i = 0; i < 8; i++) m_rdata[i*32 +: 32] = 32'hBAD0_0000 | i;
        repeat (3) @(negedge clk);
        chk("rst_s_ack", s_ack, 1'b0);
        chk("rst_m_cyc", m_cyc, 8'h00);
        chk("rst_s_rdata", s_rdata, 32'h0);
        chk("rst_err_flag", err_flag, 1'b0);
        chk("rst_err_addr", err_addr, 16'h0);
        chk("rst_err_stb", err_stb, 1'b0);
        chk("rst_shared", {m_addr, m_wdata, m_wmsk, m_we}, 49'h0);
        rst = 1'b0;

        // Read slave 2 with a stray ack on slave 5 that must be ignored.
        noise_a = 8'h20;
        txn(16'h2004, 1'b0, 32'h0, 4'h0, 1, 32'h12345678, 32'h12345678, 1'b0, 8'h04, 2, 1);
        noise_a = 8'h00;
        chk("read_err_flag", err_flag, 1'b0);

        txn(16'h7ABC, 1'b1, 32'h55AA55AA, 4'b0011, 5, 32'h77777777, 32'h0, 1'b0, 8'h80, 6, 5);

        // Reset in the middle of a request to slave 4.
        repeat (3) @(negedge clk);
        dly_a = 0; s_addr = 16'h4100; s_we = 1'b0; s_cyc = 1'b1;
        repeat (4) @(negedge clk);
        chk("mid_req_m_cyc", m_cyc, 8'h10);
        rst = 1'b1; s_cyc = 1'b0;
        @(negedge clk);
        chk("mid_rst_m_cyc", m_cyc, 8'h00);
        chk("mid_rst_s_ack", s_ack, 1'b0);
        chk("mid_rst_err_flag", err_flag, 1'b0);
        rst = 1'b0;
        txn(16'h0FFF, 1'b0, 32'h0, 4'h0, 2, 32'hA5A50F0F, 32'hA5A50F0F, 1'b0, 8'h01, 3, 2);

        // Watchdog timeout on slave 3.
        txn(16'h3456, 1'b0, 32'h0, 4'h0, 0, 32'h11111111, 32'hDEADBEEF, 1'b1, 8'h08, 17, 16);
        chk("timeout_err_flag", err_flag, 1'b1);
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        chk("err_clr_clears", err_flag, 1'b0);
        chk("err_addr_kept", err_addr, 16'h3456);

        // Decode error, then a decode error with err_clr held high.
        txn(16'hA000, 1'b0, 32'h0, 4'h0, 0, 32'h0, 32'hDEADBEEF, 1'b1, 8'h00, 2, 0);
        err_clr = 1'b1;
        txn(16'hF123, 1'b1, 32'h0BADCAFE, 4'hF, 0, 32'h0, 32'hDEADBEEF, 1'b1, 8'h00, 2, 0);
        err_clr = 1'b0;

        // Ack exactly on the watchdog terminal count.
        txn(16'h1010, 1'b0, 32'h0, 4'h0, 16, 32'hC0FFEE01, 32'hC0FFEE01, 1'b0, 8'h02, 17, 16);

        // Watchdog disabled: a 1000-cycle slave still completes.
        repeat (3) @(negedge clk);
        m_rdata[6*32 +: 32] = 32'hCAFEF00D;
        s_addr = 16'h6001; s_we = 1'b0; s_wdata = '0; s_wmsk = '0;
        q_b.push_back('{rdata: 32'hCAFEF00D, err: 1'b0, addr: 16'h6001});
        s_cyc_b = 1'b1;
        lat = 0;
        while (!s_ack_b && lat < 1500) begin
            @(negedge clk);
            lat++;
        end
        s_cyc_b = 1'b0;
        chk("b_ack_latency", lat, 1001);
        chk("b_err_flag", err_flag_b, 1'b0);

        repeat (5) @(negedge clk);
        chk("scoreboard_a_empty", q_a.size(), 0);
        chk("scoreboard_b_empty", q_b.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
